pim_bus_responder: RTL
======================

Name: pim_bus_responder

Overview:
- PIM-side end of the core's PIM bus port: the responder for memory-mapped PIM accesses issued by the bus and DMA.
- Decodes the PIM address window into a control/status register, a weight-write port, an activation FIFO and a result FIFO.
- Drives the PIM macro's weight/activation inputs, collects macro results, and returns read data to the bus with one-cycle latency.

Parameters:
XLEN, 32, bus data/address width
PIM_CTRL, 32'h4000_0010, control/status register address
PIM_R, 32'h4000_0020, result read port address
PIM_W_WEIGHT, 32'h4000_0040, weight write port address
PIM_W_ACTIVATION, 32'h4000_0080, activation write port address
FIFO_DEPTH, 8, depth of activation and result FIFOs (power of 2)
WL_ADDR_W, 6, macro word-line address width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_address  in  XLEN  bus address
i_write  in  1  bus write strobe, one access per cycle
i_read  in  1  bus read strobe
i_data  in  XLEN  bus write data
o_data  out  XLEN  bus read data, registered
o_weight_en  out  1  one-cycle weight write pulse to macro
o_wl_addr  out  WL_ADDR_W  word-line address for weight write
o_weight_data  out  XLEN  weight word
o_act_en  out  1  one-cycle activation valid to macro
o_act_data  out  XLEN  activation word
i_result_valid  in  1  macro result valid
i_result  in  XLEN  macro result word
o_busy  out  1  computation in progress

Behaviour:
- Reset: all outputs 0; FIFOs empty; WL pointer 0; FSM IDLE; all sticky flags 0. Reset mid-operation aborts immediately; no partial output persists.
- Address decode uses a full XLEN compare. Accesses to unmapped addresses: writes ignored, reads return 0.
- CTRL write:
  - bit0 start: accepted only in IDLE with N = i_data[15:8] nonzero. Latches N, clears done, enters RUN.
  - bit1 clr_wl: WL pointer set to 0 the next cycle.
  - bit2 clr_err: clears all sticky flags.
  - Start while busy or with N=0 is ignored.
- CTRL read (next cycle):
  - [0] busy, [1] done (sticky)
  - [11:8] act FIFO level, [19:16] result FIFO level
  - [24] act_overflow, [25] res_overflow, [26] res_underflow, [27] weight_while_busy
- W_WEIGHT write:
  - In IDLE: the next cycle drives o_weight_en=1, o_wl_addr=pointer, o_weight_data=i_data. Pointer then increments and wraps from 2^WL_ADDR_W-1 to 0.
  - In RUN/WAIT: write dropped, flag [27] set.
- W_ACTIVATION write: pushed to act FIFO in any state. If full and no pop that cycle: dropped, act_overflow set. Push while full with a simultaneous pop is accepted.
- FSM:
  - IDLE: o_busy=0.
  - RUN (o_busy=1): each cycle with FIFO non-empty and issued<N, pop one word; o_act_en=1 and o_act_data=word the next cycle; issued++. When issued==N, go to WAIT.
  - WAIT (o_busy=1): when received==N, set done and go to IDLE the next cycle.
- Results: i_result_valid pushes i_result into the result FIFO in any state and increments received in RUN/WAIT. If the FIFO is full, the word is dropped and res_overflow is set, but received still increments.
- PIM_R read: pops the result FIFO; o_data = popped word the next cycle. If empty: o_data=0, res_underflow set. A push and pop in the same cycle are both honoured.
- o_data holds its value until the next read. Simultaneous i_read and i_write: both performed, read first.
- Counters issued/received are 8 bits wide; N ≤ 255.

Test Plan:
- Reset check: assert i_rst mid-RUN -> o_busy, o_act_en, o_weight_en, o_data go 0 immediately; CTRL read returns 0.
- Weight sequence: write 0xA0..0xA3 to 0x4000_0040 with clr_wl first -> pulses carry wl_addr 0,1,2,3 with matching data. With WL_ADDR_W=2, a 5th write wraps to wl_addr 0.
- Compute: push acts 1,2,3, write CTRL=0x0301 -> three o_act_en pulses with data 1,2,3, o_busy high. Macro returns 0x11,0x22,0x33 -> done=1, busy=0. PIM_R reads return 0x11,0x22,0x33, and a 4th read returns 0 with underflow=1.
- Overflow: 9 activation writes in IDLE -> level 8, act_overflow=1; clr_err clears the flag.
- Busy guards: weight write during RUN -> no o_weight_en, flag[27]=1. Second start during RUN is ignored and N is unchanged.
- Stall: start N=2 with an empty FIFO -> FSM stays in RUN with no pulses until activations are written, then completes normally.

Source files
------------

// File: rtl/pim_bus_responder.sv
// PIM bus responder: decodes the PIM window into CTRL, weight,
// activation and result ports, and sequences activations to the macro.
module pim_bus_responder #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] PIM_CTRL = 'h4000_0010,
  parameter logic [XLEN-1:0] PIM_R = 'h4000_0020,
  parameter logic [XLEN-1:0] PIM_W_WEIGHT = 'h4000_0040,
  parameter logic [XLEN-1:0] PIM_W_ACTIVATION = 'h4000_0080,
  parameter int FIFO_DEPTH = 8,
  parameter int WL_ADDR_W = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [XLEN-1:0]      i_address,
  input  logic                 i_write,
  input  logic                 i_read,
  input  logic [XLEN-1:0]      i_data,
  output logic [XLEN-1:0]      o_data,
  output logic                 o_weight_en,
  output logic [WL_ADDR_W-1:0] o_wl_addr,
  output logic [XLEN-1:0]      o_weight_data,
  output logic                 o_act_en,
  output logic [XLEN-1:0]      o_act_data,
  input  logic                 i_result_valid,
  input  logic [XLEN-1:0]      i_result,
  output logic                 o_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

  state_t state_q, state_d;
  logic [7:0] n_q, n_d, issued_q, issued_d, received_q, received_d;
  logic done_q, done_d;
  logic aov_q, aov_d, rov_q, rov_d, rud_q, rud_d, wwb_q, wwb_d;
  logic [WL_ADDR_W-1:0] wl_ptr_q, wl_ptr_d, wl_addr_q, wl_addr_d;
  logic [PW-1:0] aw_q, aw_d, ar_q, ar_d, rw_q, rw_d, rr_q, rr_d;
  logic [CW-1:0] acnt_q, acnt_d, rcnt_q, rcnt_d;
  logic [XLEN-1:0] data_q, data_d, wdata_q, wdata_d, adata_q, adata_d;
  logic wen_q, wen_d, aen_q, aen_d;
  logic [XLEN-1:0] act_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] res_mem_q [FIFO_DEPTH];

  logic hit_ctrl, hit_r, hit_w, hit_a;
  logic a_push, a_pop, r_pop, r_push;
  logic [XLEN-1:0] status;

  assign hit_ctrl = i_address == PIM_CTRL;
  assign hit_r = i_address == PIM_R;
  assign hit_w = i_address == PIM_W_WEIGHT;
  assign hit_a = i_address == PIM_W_ACTIVATION;

  assign o_data = data_q;
  assign o_weight_en = wen_q;
  assign o_wl_addr = wl_addr_q;
  assign o_weight_data = wdata_q;
  assign o_act_en = aen_q;
  assign o_act_data = adata_q;
  assign o_busy = state_q != S_IDLE;

  // FIFO control, bus decode, sticky flags and sequencing FSM
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    issued_d = issued_q;
    received_d = received_q;
    done_d = done_q;
    aov_d = aov_q;
    rov_d = rov_q;
    rud_d = rud_q;
    wwb_d = wwb_q;
    wl_ptr_d = wl_ptr_q;
    wl_addr_d = wl_addr_q;
    wdata_d = wdata_q;
    wen_d = 1'b0;
    aen_d = 1'b0;
    adata_d = adata_q;
    data_d = data_q;

    a_pop = state_q == S_RUN && acnt_q != '0 && issued_q < n_q;
    a_push = i_write && hit_a && (acnt_q != FULL || a_pop);
    r_pop = i_read && hit_r && rcnt_q != '0;
    r_push = i_result_valid && (rcnt_q != FULL || r_pop);

    aw_d = aw_q + PW'(a_push);
    ar_d = ar_q + PW'(a_pop);
    acnt_d = acnt_q + CW'(a_push) - CW'(a_pop);
    rw_d = rw_q + PW'(r_push);
    rr_d = rr_q + PW'(r_pop);
    rcnt_d = rcnt_q + CW'(r_push) - CW'(r_pop);

    status = '0;
    status[0] = state_q != S_IDLE;
    status[1] = done_q;
    status[8 +: CW] = acnt_q;
    status[16 +: CW] = rcnt_q;
    status[24] = aov_q;
    status[25] = rov_q;
    status[26] = rud_q;
    status[27] = wwb_q;

    // read is serviced from pre-write state
    if (i_read) begin
      data_d = '0;
      if (hit_ctrl) data_d = status;
      else if (r_pop) data_d = res_mem_q[rr_q];
      else if (hit_r) rud_d = 1'b1;
    end

    if (i_write && hit_ctrl) begin
      if (i_data[1]) wl_ptr_d = '0;
      if (i_data[2]) begin
        aov_d = 1'b0;
        rov_d = 1'b0;
        rud_d = 1'b0;
        wwb_d = 1'b0;
      end
      if (i_data[0] && state_q == S_IDLE && i_data[15:8] != 8'd0) begin
        n_d = i_data[15:8];
        done_d = 1'b0;
        issued_d = 8'd0;
        received_d = 8'd0;
        state_d = S_RUN;
      end
    end

    if (i_write && hit_w) begin
      if (state_q == S_IDLE) begin
        wen_d = 1'b1;
        wl_addr_d = wl_ptr_q;
        wdata_d = i_data;
        wl_ptr_d = wl_ptr_q + 1'b1;
      end else begin
        wwb_d = 1'b1;
      end
    end

    if (i_write && hit_a && !a_push) aov_d = 1'b1;
    if (i_result_valid && !r_push) rov_d = 1'b1;
    if (i_result_valid && state_q != S_IDLE)
      received_d = received_q + 8'd1;

    unique case (state_q)
      S_RUN: begin
        if (a_pop) begin
          aen_d = 1'b1;
          adata_d = act_mem_q[ar_q];
          issued_d = issued_q + 8'd1;
          if (issued_q + 8'd1 == n_q) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (received_q == n_q) begin
          done_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  // FIFO storage, written only on accepted pushes
  always_ff @(posedge i_clk) begin
    if (a_push) act_mem_q[aw_q] <= i_data;
    if (r_push) res_mem_q[rw_q] <= i_result;
  end

  // state and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      n_q <= '0;
      issued_q <= '0;
      received_q <= '0;
      done_q <= 1'b0;
      aov_q <= 1'b0;
      rov_q <= 1'b0;
      rud_q <= 1'b0;
      wwb_q <= 1'b0;
      wl_ptr_q <= '0;
      wl_addr_q <= '0;
      aw_q <= '0;
      ar_q <= '0;
      rw_q <= '0;
      rr_q <= '0;
      acnt_q <= '0;
      rcnt_q <= '0;
      data_q <= '0;
      wdata_q <= '0;
      adata_q <= '0;
      wen_q <= 1'b0;
      aen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      issued_q <= issued_d;
      received_q <= received_d;
      done_q <= done_d;
      aov_q <= aov_d;
      rov_q <= rov_d;
      rud_q <= rud_d;
      wwb_q <= wwb_d;
      wl_ptr_q <= wl_ptr_d;
      wl_addr_q <= wl_addr_d;
      aw_q <= aw_d;
      ar_q <= ar_d;
      rw_q <= rw_d;
      rr_q <= rr_d;
      acnt_q <= acnt_d;
      rcnt_q <= rcnt_d;
      data_q <= data_d;
      wdata_q <= wdata_d;
      adata_q <= adata_d;
      wen_q <= wen_d;
      aen_q <= aen_d;
    end
  end
endmodule
